// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory unit: each 32-bit load/store becomes two 16-bit SRAM
// transfers (low half first) with programmable write wait states.
module mem_sram_ctrl #(
   parameter int ADDR_W    = 17,
   parameter int WAIT_CYC  = 1,
   parameter int DATA_BASE = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic [31:0]       ALU_result,
   input  logic [31:0]       ST_val,
   output logic [31:0]       MEM_read_value,
   output logic              Freeze,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic [15:0]       SRAM_DQ_out,
   output logic              SRAM_DQ_oe,
   input  logic [15:0]       SRAM_DQ_in,
   output logic              SRAM_WE_N,
   output logic              SRAM_OE_N
);
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
   localparam logic [2:0] LAST_PHASE = 3'(WAIT_CYC);

   state_t            state;
   logic [2:0]        phase;
   logic [2:0]        next_phase;
   logic              is_write;
   logic [ADDR_W-2:0] word_addr;
   logic [15:0]       st_hi;
   logic [31:0]       offset;
   logic              request;
   logic              unused_offset;

   // Only the word-address bits that fit the SRAM are kept; the rest wrap away.
   assign offset        = ALU_result - 32'(DATA_BASE);
   assign unused_offset = ^offset;
   assign request       = MEM_R_EN | MEM_W_EN;
   assign next_phase    = phase + 3'd1;

   assign Freeze = !rst && ((state == IDLE && request) || state == LO || state == HI);

   // SRAM pins are registered; each phase ends with one hold cycle where the
   // write strobe is already high but address and data are still driven.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         phase          <= 3'd0;
         is_write       <= 1'b0;
         word_addr      <= '0;
         st_hi          <= 16'h0;
         MEM_read_value <= 32'h0;
         SRAM_ADDR      <= '0;
         SRAM_DQ_out    <= 16'h0;
         SRAM_DQ_oe     <= 1'b0;
         SRAM_WE_N      <= 1'b1;
         SRAM_OE_N      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  is_write   <= MEM_W_EN;
                  word_addr  <= offset[ADDR_W:2];
                  st_hi      <= ST_val[31:16];
                  phase      <= 3'd0;
                  state      <= LO;
                  SRAM_ADDR  <= {offset[ADDR_W:2], 1'b0};
                  SRAM_DQ_oe <= MEM_W_EN;
                  SRAM_WE_N  <= !MEM_W_EN;
                  SRAM_OE_N  <= MEM_W_EN;
                  if (MEM_W_EN) begin
                     SRAM_DQ_out <= ST_val[15:0];
                  end
               end
            end
            LO: begin
               if (phase == LAST_PHASE) begin
                  if (!is_write) begin
                     MEM_read_value[15:0] <= SRAM_DQ_in;
                  end else begin
                     SRAM_DQ_out <= st_hi;
                  end
                  phase     <= 3'd0;
                  state     <= HI;
                  SRAM_ADDR <= {word_addr, 1'b1};
                  SRAM_WE_N <= !is_write;
               end else begin
                  phase     <= next_phase;
                  SRAM_WE_N <= !(is_write && (next_phase < LAST_PHASE));
               end
            end
            HI: begin
               if (phase == LAST_PHASE) begin
                  if (!is_write) begin
                     MEM_read_value[31:16] <= SRAM_DQ_in;
                  end
                  phase      <= 3'd0;
                  state      <= DONE;
                  SRAM_DQ_oe <= 1'b0;
                  SRAM_WE_N  <= 1'b1;
                  SRAM_OE_N  <= 1'b1;
               end else begin
                  phase     <= next_phase;
                  SRAM_WE_N <= !(is_write && (next_phase < LAST_PHASE));
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl: a word-level reference memory predicts
// load data and half-word traffic, a monitor checks each completed access.
module tb_mem_sram_ctrl;
   localparam int ADDR_W    = 17;
   localparam int WAIT_CYC  = 1;
   localparam int DATA_BASE = 1024;
   localparam int TIMEOUT   = 64;
   localparam int WORDS     = 1 << (ADDR_W - 1);

   logic              clk;
   logic              rst;
   logic              MEM_R_EN;
   logic              MEM_W_EN;
   logic [31:0]       ALU_result;
   logic [31:0]       ST_val;
   logic [31:0]       MEM_read_value;
   logic              Freeze;
   logic [ADDR_W-1:0] SRAM_ADDR;
   logic [15:0]       SRAM_DQ_out;
   logic              SRAM_DQ_oe;
   logic [15:0]       SRAM_DQ_in;
   logic              SRAM_WE_N;
   logic              SRAM_OE_N;

   typedef struct {
      bit                wr;
      logic [ADDR_W-1:0] lo;
      logic [31:0]       data;
      logic [31:0]       exp_rd;
   } item_t;

   item_t             exp_q[$];
   item_t             mon_item;
   logic [31:0]       ref_mem[int];
   int                written_q[$];
   logic [31:0]       last_rd = 32'h0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [15:0]       sram[0:(1 << ADDR_W) - 1];
   int                n_checks = 0;
   int                n_fail = 0;
   int                cyc = 0;
   bit                mon_in = 0;
   int                mon_k = 0;
   int                mon_frz = 0;
   int                mon_err = 0;

   mem_sram_ctrl #(
      .ADDR_W(ADDR_W),
      .WAIT_CYC(WAIT_CYC),
      .DATA_BASE(DATA_BASE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .MEM_R_EN(MEM_R_EN),
      .MEM_W_EN(MEM_W_EN),
      .ALU_result(ALU_result),
      .ST_val(ST_val),
      .MEM_read_value(MEM_read_value),
      .Freeze(Freeze),
      .SRAM_ADDR(SRAM_ADDR),
      .SRAM_DQ_out(SRAM_DQ_out),
      .SRAM_DQ_oe(SRAM_DQ_oe),
      .SRAM_DQ_in(SRAM_DQ_in),
      .SRAM_WE_N(SRAM_WE_N),
      .SRAM_OE_N(SRAM_OE_N)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Simple SRAM: writes on a clock edge while strobed, reads are combinational.
   always @(posedge clk) begin
      if (!SRAM_WE_N && SRAM_DQ_oe) sram[SRAM_ADDR] <= SRAM_DQ_out;
   end
   assign SRAM_DQ_in = SRAM_OE_N ? 16'hA5A5 : sram[SRAM_ADDR];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int wordIndex(input logic [31:0] a);
      logic [31:0] wa;
      wa = (a - 32'(DATA_BASE)) >> 2;
      return int'(wa % WORDS);
   endfunction

   // Expected pin values for the k-th transfer cycle of an access.
   function automatic bit cycleOk(input item_t it, input int k);
      int                hw;
      int                pos;
      logic [15:0]       half;
      logic [ADDR_W-1:0] a;
      if (k > 2 * WAIT_CYC + 1) return 1'b0;
      hw   = (k > WAIT_CYC) ? 1 : 0;
      pos  = k - hw * (WAIT_CYC + 1);
      a    = it.lo + ADDR_W'(hw);
      half = (hw == 1) ? it.data[31:16] : it.data[15:0];
      if (SRAM_ADDR !== a) return 1'b0;
      if (it.wr)
         return SRAM_DQ_oe === 1'b1 && SRAM_OE_N === 1'b1 && SRAM_DQ_out === half &&
                SRAM_WE_N === ((pos < WAIT_CYC) ? 1'b0 : 1'b1);
      return SRAM_DQ_oe === 1'b0 && SRAM_OE_N === 1'b0 && SRAM_WE_N === 1'b1;
   endfunction

   // Issues one access at a negedge and returns at the negedge of its DONE cycle.
   task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [31:0] data);
      item_t it;
      int    widx;
      int    t;
      MEM_R_EN   = rd;
      MEM_W_EN   = wr;
      ALU_result = addr;
      ST_val     = data;
      widx       = wordIndex(addr);
      it.wr      = wr;
      it.lo      = ADDR_W'(widx * 2);
      it.data    = data;
      if (wr) begin
         ref_mem[widx] = data;
         written_q.push_back(widx);
      end else begin
         last_rd = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
      end
      it.exp_rd = last_rd;
      last_addr = ADDR_W'(widx * 2 + 1);
      exp_q.push_back(it);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (Freeze && t < TIMEOUT);
      checkOutput("done_reached", Freeze, 0);
   endtask

   task automatic idleCycles(input int n);
      MEM_R_EN   = 1'b0;
      MEM_W_EN   = 1'b0;
      ALU_result = $urandom();
      ST_val     = $urandom();
      repeat (n) begin
         @(negedge clk);
         checkOutput("idle_freeze", Freeze, 0);
         checkOutput("idle_we_n", SRAM_WE_N, 1);
         checkOutput("idle_oe_n", SRAM_OE_N, 1);
         checkOutput("idle_dq_oe", SRAM_DQ_oe, 0);
         checkOutput("idle_addr_hold", SRAM_ADDR, last_addr);
         checkOutput("idle_rd_value", MEM_read_value, last_rd);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_freeze"}, Freeze, 0);
      checkOutput({tag, "_we_n"}, SRAM_WE_N, 1);
      checkOutput({tag, "_oe_n"}, SRAM_OE_N, 1);
      checkOutput({tag, "_dq_oe"}, SRAM_DQ_oe, 0);
      checkOutput({tag, "_addr"}, SRAM_ADDR, 0);
      checkOutput({tag, "_dq_out"}, SRAM_DQ_out, 0);
      checkOutput({tag, "_rd_value"}, MEM_read_value, 0);
   endtask

   // Monitor: follows each access from its first frozen cycle to DONE.
   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         mon_in  = 0;
         mon_k   = 0;
         mon_frz = 0;
         mon_err = 0;
      end else begin
         if (Freeze) begin
            mon_in = 1;
            mon_frz++;
         end
         if (mon_in) begin
            if (SRAM_DQ_oe || !SRAM_OE_N) begin
               if (exp_q.size() == 0 || !cycleOk(exp_q[0], mon_k)) mon_err++;
               mon_k++;
            end else if (!SRAM_WE_N) begin
               mon_err++;
            end
            if (!Freeze) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("[TB] FAIL scoreboard_empty: got an access, expected none at cycle %0d", cyc);
               end else begin
                  mon_item = exp_q.pop_front();
                  checkOutput("rd_value", MEM_read_value, mon_item.exp_rd);
                  checkOutput("frozen_cycles", mon_frz, 2 * WAIT_CYC + 3);
                  checkOutput("transfer_cycles", mon_k, 2 * WAIT_CYC + 2);
                  checkOutput("pin_sequence_errors", mon_err, 0);
                  if (mon_item.wr) begin
                     checkOutput("sram_lo_half", sram[mon_item.lo], mon_item.data[15:0]);
                     checkOutput("sram_hi_half", sram[mon_item.lo | ADDR_W'(1)], mon_item.data[31:16]);
                  end
               end
               mon_in  = 0;
               mon_k   = 0;
               mon_frz = 0;
               mon_err = 0;
            end
         end
      end
   end

   initial begin
      int start;
      int widx;
      int kind;
      rst        = 1'b0;
      MEM_R_EN   = 1'b1;
      MEM_W_EN   = 1'b1;
      ALU_result = 32'd1032;
      ST_val     = 32'h1234_5678;
      #2 rst = 1'b1;
      #1 checkResetValues("reset");
      @(negedge clk);
      checkOutput("reset_freeze_held", Freeze, 0);
      @(negedge clk);
      rst = 1'b0;
      idleCycles(20);

      start = cyc;
      applyStimulus(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF);
      checkOutput("store_occupancy", cyc - start + 1, 2 * WAIT_CYC + 4);
      applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);
      idleCycles(1);

      start = cyc;
      applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'd1036, $urandom());
      checkOutput("back_to_back_cycles", cyc - start + 1, 2 * (2 * WAIT_CYC + 4));

      applyStimulus(1'b0, 1'b1, 32'd0, 32'h0BAD_F00D);
      applyStimulus(1'b0, 1'b1, 32'(DATA_BASE + 4 * WORDS + 2), 32'h1357_9BDF);
      applyStimulus(1'b1, 1'b0, 32'd3, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'(DATA_BASE + 1), 32'h0);
      idleCycles(2);

      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 4));
         if (kind == 2 && written_q.size() == 0) kind = 0;
         case (kind)
            0, 1: begin
               if ($urandom_range(0, 1) == 0)
                  applyStimulus(1'b0, 1'b1, 32'(DATA_BASE + 4 * int'($urandom_range(0, 31)) +
                                int'($urandom_range(0, 3))), $urandom());
               else
                  applyStimulus(1'b0, 1'b1, $urandom(), $urandom());
            end
            2: begin
               widx = written_q[$urandom_range(0, written_q.size() - 1)];
               applyStimulus(1'b1, 1'b0, 32'(DATA_BASE + 4 * widx + int'($urandom_range(0, 3))), 32'h0);
            end
            3: applyStimulus(1'b1, 1'b1, 32'(DATA_BASE + 4 * int'($urandom_range(0, 31))), $urandom());
            default: idleCycles(int'($urandom_range(1, 3)));
         endcase
      end
      idleCycles(2);

      // Abort a store during its high-half phase.
      MEM_R_EN   = 1'b0;
      MEM_W_EN   = 1'b1;
      ALU_result = 32'(DATA_BASE + 4 * 500);
      ST_val     = 32'hCAFE_F00D;
      repeat (3) @(negedge clk);
      checkOutput("pre_abort_we_n", SRAM_WE_N, 0);
      checkOutput("pre_abort_addr", SRAM_ADDR, 1001);
      #2 rst = 1'b1;
      #1 checkResetValues("abort");
      last_rd   = 32'h0;
      last_addr = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("sram_aborted_lo", sram[1000], 16'hF00D);
      start = cyc;
      applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);
      checkOutput("post_abort_occupancy", cyc - start + 1, 2 * WAIT_CYC + 4);
      idleCycles(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion before 500000");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Multi-cycle data-memory access unit for the MIPS pipeline. It sits in the MEM stage, directly downstream of the EXE/MEM pipeline register and upstream of the MEM/WB pipeline register. It turns one 32-bit load or store into two 16-bit transfers on an external asynchronous SRAM with programmable wait states. While an access is in progress it asserts `Freeze` so the pipeline registers and PC hold.

## Interface
- `ADDR_W`, 17: SRAM half-word address width.
- `WAIT_CYC`, 1: cycles `SRAM_WE_N` is held low per half-word phase. Legal range 1..7.
- `DATA_BASE`, 1024: byte offset subtracted from `ALU_result` before addressing.

- `clk` input 1: pipeline clock, all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `MEM_R_EN` input 1: load request from the EXE/MEM register.
- `MEM_W_EN` input 1: store request from the EXE/MEM register.
- `ALU_result` input 32: byte address.
- `ST_val` input 32: store data.
- `MEM_read_value` output 32: registered load data, forwarded to the MEM/WB register.
- `Freeze` output 1: hold request to all pipeline registers and the PC.
- `SRAM_ADDR` output ADDR_W: half-word address.
- `SRAM_DQ_out` output 16: write data.
- `SRAM_DQ_oe` output 1: write-data drive enable, for the top-level tristate.
- `SRAM_DQ_in` input 16: read data.
- `SRAM_WE_N` output 1: active-low write strobe.
- `SRAM_OE_N` output 1: active-low output enable.

## Operation
- Word address `wa = (ALU_result - DATA_BASE) >> 2`, computed modulo 2^32. Bits [1:0] of `ALU_result` are ignored.
- Half addresses:
  - Low half is `{wa, 0}`.
  - High half is `{wa, 1}`.
  - Both are truncated to `ADDR_W` bits, so addresses wrap silently.
- The low half is bits [15:0] and is always transferred first.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: on a clock edge with `MEM_R_EN | MEM_W_EN`, latch `wa`, `ST_val` and op, load the phase counter with 0, then go to LO. If both enables are high the access is a write.
  - LO: lasts `WAIT_CYC+1` cycles.
    - Drive the low address.
    - Write: `SRAM_DQ_oe=1`, `SRAM_DQ_out=ST_val[15:0]`, `SRAM_WE_N=0` in the first `WAIT_CYC` cycles and 1 in the last cycle (data/address hold).
    - Read: `SRAM_OE_N=0` in all cycles. Capture `SRAM_DQ_in` into `MEM_read_value[15:0]` on the edge ending the last cycle.
    - Then go to HI.
  - HI: same as LO for the high address and bits [31:16], then go to DONE.
  - DONE: one cycle, SRAM idle. `MEM_read_value` holds the full word. Always go to IDLE.
- `Freeze` = `(IDLE & (MEM_R_EN | MEM_W_EN)) | LO | HI`. It is 0 in DONE, so the pipeline advances on the DONE edge.
- Output sourcing:
  - SRAM outputs decode only from state and latched registers, never from live inputs.
  - When idle: `SRAM_WE_N=1`, `SRAM_OE_N=1`, `SRAM_DQ_oe=0`, and `SRAM_ADDR` holds its last value.
- `MEM_read_value` is changed only by reads. Writes leave it untouched.
- Both enables low in IDLE: no SRAM activity and `Freeze=0`.

## Timing
- Reset values:
  - state IDLE, phase counter 0.
  - `MEM_read_value=0`, `SRAM_ADDR=0`, `SRAM_DQ_out=0`.
  - `SRAM_DQ_oe=0`, `SRAM_WE_N=1`, `SRAM_OE_N=1`.
  - `Freeze` forced 0 while `rst` is high.
- Access occupancy is `2*WAIT_CYC+4` cycles: 1 IDLE, `2*(WAIT_CYC+1)` LO/HI, 1 DONE.
  - `Freeze` is high for `2*WAIT_CYC+3` consecutive cycles.
  - With `WAIT_CYC=1`: 6 cycles total, 5 frozen.
- Load data is valid in the DONE cycle and is sampled by the MEM/WB register on the DONE edge.
- Back-to-back accesses: the next instruction's request is seen in the IDLE cycle immediately after DONE. There is no extra bubble.
- Reset mid-access is asynchronous:
  - SRAM strobes deassert and state returns to IDLE in the same cycle.
  - An aborted store may leave only the low half written. This is accepted.
- The enables are sampled only in IDLE. Changes during LO/HI/DONE are ignored.

## Test plan
- Reset check: assert `rst` mid-cycle -> all outputs take their reset values immediately. `Freeze=0` with enables high during reset.
- Store, `WAIT_CYC=1`, `ALU_result=1032`, `ST_val=0xDEADBEEF`:
  - `SRAM_ADDR=4` then `5`.
  - `SRAM_DQ_out=0xBEEF` then `0xDEAD`.
  - `SRAM_WE_N` low for exactly 1 cycle per phase.
  - `Freeze` high 5 cycles. `MEM_read_value` unchanged.
- Load of the same address from the SRAM model -> `OE_N` low for 4 cycles, `MEM_read_value=0xDEADBEEF` in DONE, `Freeze=0` in DONE.
- Load immediately followed by store to 1036 -> second access starts in the cycle after DONE, `SRAM_ADDR=6`,`7`, total 12 cycles for both.
- Idle traffic: enables low for 20 cycles -> `Freeze=0`, `WE_N`/`OE_N` stay 1, `SRAM_DQ_oe=0`.
- Reset during HI of a store -> `WE_N=1` and `DQ_oe=0` at once, state IDLE. A following load completes normally in 6 cycles.
